// File: rtl/eth_rx_speed_ctrl.sv
// Receive-side sequencer for axis_gmii_rx at 10/100/1000 Mb/s from a fixed 125 MHz clock.
// Speed and rx_enable changes land only between frames; each frame is passed or dropped whole.
module eth_rx_speed_ctrl #(
  parameter int PRESCALE_100  = 5,
  parameter int PRESCALE_10   = 50,
  parameter int GAP_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cfg_speed,
  input  logic        cfg_speed_valid,
  output logic        cfg_speed_ready,
  input  logic        rx_enable,
  input  logic        gmii_rx_dv,
  input  logic        m_axis_tvalid,
  input  logic        m_axis_tlast,
  output logic        gmii_rx_dv_out,
  output logic        rx_clk_enable,
  output logic        rx_mii_select,
  output logic [1:0]  speed,
  output logic        busy,
  output logic [15:0] drop_count
);

  localparam int PMAX = (PRESCALE_10 > PRESCALE_100) ? PRESCALE_10 : PRESCALE_100;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int EMAX = (GAP_CYCLES > DRAIN_TIMEOUT) ? GAP_CYCLES : DRAIN_TIMEOUT;
  localparam int CW   = $clog2(EMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_DRAIN  = 3'd2,
    S_BLOCK  = 3'd3,
    S_SWITCH = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    speed_req;
  logic [PW-1:0] pre_cnt, pre_max, pre_max_new;
  logic [CW-1:0] ev_cnt;
  logic          accept, ec;

  function automatic logic [PW-1:0] period_max(input logic [1:0] s);
    case (s)
      2'b00:   period_max = PW'(PRESCALE_10 - 1);
      2'b01:   period_max = PW'(PRESCALE_100 - 1);
      default: period_max = '0;
    endcase
  endfunction

  assign ec          = rx_clk_enable;
  assign accept      = cfg_speed_valid && (state == S_IDLE);
  assign pre_max     = period_max(speed);
  assign pre_max_new = period_max(speed_req);

  // The SWITCH cycle stands in for count position 0 of the new rate, so the
  // first new-rate pulse lands right after it and the period stays exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt       <= '0;
      rx_clk_enable <= 1'b0;
    end else if (state == S_SWITCH) begin
      pre_cnt       <= (pre_max_new == '0) ? '0 : PW'(1);
      rx_clk_enable <= 1'b1;
    end else begin
      pre_cnt       <= (pre_cnt >= pre_max) ? '0 : pre_cnt + 1'b1;
      rx_clk_enable <= (pre_cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_req     <= 2'b10;
      speed         <= 2'b10;
      rx_mii_select <= 1'b0;
    end else begin
      if (accept)
        speed_req <= cfg_speed[1] ? 2'b10 : cfg_speed;
      if (state == S_SWITCH) begin
        speed         <= speed_req;
        rx_mii_select <= ~speed_req[1];
      end
    end
  end

  // Shared EC counter for DRAIN timeout and GAP quiet run; cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ev_cnt <= '0;
    else if (state_nxt != state)
      ev_cnt <= '0;
    else if (ec && (state == S_DRAIN || state == S_GAP))
      ev_cnt <= ev_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = S_SWITCH;
        else if (ec && gmii_rx_dv)
          state_nxt = rx_enable ? S_ACTIVE : S_BLOCK;
      end
      S_ACTIVE:
        if (ec && !gmii_rx_dv) state_nxt = S_DRAIN;
      S_DRAIN:
        if ((m_axis_tvalid && m_axis_tlast) ||
            (ec && ev_cnt == CW'(DRAIN_TIMEOUT - 1)))
          state_nxt = S_GAP;
      S_BLOCK:
        if (ec && !gmii_rx_dv) state_nxt = S_GAP;
      S_SWITCH:
        state_nxt = S_GAP;
      S_GAP: begin
        if (ec) begin
          if (gmii_rx_dv)
            state_nxt = S_BLOCK;
          else if (ev_cnt == CW'(GAP_CYCLES - 1))
            state_nxt = S_IDLE;
        end
      end
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_speed_ready = (state == S_IDLE);
    busy            = (state != S_IDLE);
    gmii_rx_dv_out  = gmii_rx_dv &&
                      ((state == S_ACTIVE) || (state == S_IDLE && state_nxt == S_ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if (state != S_BLOCK && state_nxt == S_BLOCK && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end

endmodule

// File: tb/tb_eth_rx_speed_ctrl.sv
// Directed and randomized checks of eth_rx_speed_ctrl against a frame-level model:
// expected drops, enable period per speed and the number of cycles until re-arm.
module tb_eth_rx_speed_ctrl;

  localparam int GAP = 4;
  localparam int DRT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_speed;
  logic        cfg_speed_valid;
  logic        cfg_speed_ready;
  logic        rx_enable;
  logic        gmii_rx_dv;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        gmii_rx_dv_out;
  logic        rx_clk_enable;
  logic        rx_mii_select;
  logic [1:0]  speed;
  logic        busy;
  logic [15:0] drop_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_drops = 0;

  eth_rx_speed_ctrl #(
    .PRESCALE_100(5), .PRESCALE_10(50), .GAP_CYCLES(GAP), .DRAIN_TIMEOUT(DRT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_speed(cfg_speed), .cfg_speed_valid(cfg_speed_valid), .cfg_speed_ready(cfg_speed_ready),
    .rx_enable(rx_enable), .gmii_rx_dv(gmii_rx_dv),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .gmii_rx_dv_out(gmii_rx_dv_out), .rx_clk_enable(rx_clk_enable),
    .rx_mii_select(rx_mii_select), .speed(speed), .busy(busy), .drop_count(drop_count)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_speed"}, 32'(speed), 32'(2'b10));
    chk({tag, "_mii"}, 32'(rx_mii_select), 32'(0));
    chk({tag, "_clken"}, 32'(rx_clk_enable), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_drops"}, 32'(drop_count), 32'(0));
    chk({tag, "_dvout"}, 32'(gmii_rx_dv_out), 32'(0));
    chk({tag, "_ready"}, 32'(cfg_speed_ready), 32'(1));
  endtask

  // From the first new-rate cycle: a pulse every 'period' cycles, busy until GAP pulses seen.
  task automatic rate_check(input int period);
    int last;
    last = (GAP - 1) * period + 1;
    for (int k = 0; k <= last; k++) begin
      chk("rate_clken", 32'(rx_clk_enable), 32'((k % period) == 0));
      chk("rate_busy", 32'(busy), 32'(k < last));
      tick();
    end
  endtask

  task automatic set_speed(input logic [1:0] s, input logic [1:0] exp_s, input int period);
    cfg_speed = s;
    cfg_speed_valid = 1'b1;
    #1;
    chk("req_ready", 32'(cfg_speed_ready), 32'(1));
    tick();
    cfg_speed_valid = 1'b0;
    #1;
    chk("switch_busy", 32'(busy), 32'(1));
    chk("switch_ready", 32'(cfg_speed_ready), 32'(0));
    tick();
    chk("new_speed", 32'(speed), 32'(exp_s));
    chk("new_mii", 32'(rx_mii_select), 32'(exp_s != 2'b10));
    rate_check(period);
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  // One 1000M frame of 'len' dv cycles, then a quiet tail up to the predicted re-arm point.
  task automatic send_frame(input int len, input bit en0, input int flip_at,
                            input int tl_at, input bit tl_valid);
    int idle_q;
    bit pass;
    pass = en0;
    if (!en0 && exp_drops < 16'hFFFF) exp_drops++;
    rx_enable = en0;
    for (int i = 0; i < len; i++) begin
      if (i == flip_at) rx_enable = ~rx_enable;
      gmii_rx_dv = 1'b1;
      #1;
      chk("frame_dvout", 32'(gmii_rx_dv_out), 32'(pass));
      chk("frame_clken", 32'(rx_clk_enable), 32'(1));
      chk("frame_busy", 32'(busy), 32'(i > 0));
      tick();
    end
    gmii_rx_dv = 1'b0;
    if (!pass)
      idle_q = 1 + GAP;
    else if (tl_valid && tl_at >= 1 && tl_at <= DRT)
      idle_q = tl_at + 1 + GAP;
    else
      idle_q = 1 + DRT + GAP;
    for (int q = 0; q <= idle_q; q++) begin
      m_axis_tlast  = (q == tl_at);
      m_axis_tvalid = (q == tl_at) ? tl_valid : 1'($urandom_range(0, 1));
      #1;
      chk("tail_busy", 32'(busy), 32'(q < idle_q));
      chk("tail_dvout", 32'(gmii_rx_dv_out), 32'(0));
      tick();
    end
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    chk("drop_count", 32'(drop_count), 32'(exp_drops));
  endtask

  initial begin
    rst = 1'b1;
    cfg_speed = 2'b00;
    cfg_speed_valid = 1'b0;
    rx_enable = 1'b1;
    gmii_rx_dv = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    tick();
    tick();
    chk_reset_values("reset");

    gmii_rx_dv = 1'b0;
    rst = 1'b0;
    tick();
    chk("release_clken", 32'(rx_clk_enable), 32'(1));

    // 1000M frame, 64 dv cycles, tlast one cycle into the drain
    send_frame(64, 1'b1, -1, 1, 1'b1);

    // Rate changes: 100M, 10M, then 11 maps back to 1000M
    set_speed(2'b01, 2'b01, 5);
    set_speed(2'b00, 2'b00, 50);
    set_speed(2'b11, 2'b10, 1);

    // Speed request raised mid-frame waits for drain and gap
    rx_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      gmii_rx_dv = 1'b1;
      if (i == 3) begin
        cfg_speed = 2'b01;
        cfg_speed_valid = 1'b1;
      end
      #1;
      chk("t3_ready_frame", 32'(cfg_speed_ready), 32'(i == 0));
      chk("t3_dvout", 32'(gmii_rx_dv_out), 32'(1));
      chk("t3_speed_frame", 32'(speed), 32'(2'b10));
      tick();
    end
    gmii_rx_dv = 1'b0;
    for (int q = 0; q <= 6; q++) begin
      m_axis_tvalid = (q == 1);
      m_axis_tlast  = (q == 1);
      #1;
      chk("t3_ready_tail", 32'(cfg_speed_ready), 32'(q == 6));
      chk("t3_speed_tail", 32'(speed), 32'(2'b10));
      tick();
    end
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    cfg_speed_valid = 1'b0;
    #1;
    chk("t3_switch_busy", 32'(busy), 32'(1));
    chk("t3_switch_speed", 32'(speed), 32'(2'b10));
    tick();
    chk("t3_new_speed", 32'(speed), 32'(2'b01));
    chk("t3_new_mii", 32'(rx_mii_select), 32'(1));
    rate_check(5);
    set_speed(2'b10, 2'b10, 1);

    // rx_enable low at frame start, raised mid-frame: whole frame dropped, next passes
    send_frame(20, 1'b0, 5, -1, 1'b0);
    chk("t4_drops", 32'(drop_count), 32'(1));
    send_frame(12, 1'b1, -1, 3, 1'b1);

    // dv back two ECs into GAP: dropped, and the quiet run restarts
    rx_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gmii_rx_dv = 1'b1;
      #1;
      chk("t5_dvout_pass", 32'(gmii_rx_dv_out), 32'(1));
      tick();
    end
    gmii_rx_dv = 1'b0;
    for (int q = 0; q < 4; q++) begin
      m_axis_tvalid = (q == 1);
      m_axis_tlast  = (q == 1);
      #1;
      tick();
    end
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    exp_drops++;
    for (int i = 0; i < 6; i++) begin
      gmii_rx_dv = 1'b1;
      #1;
      chk("t5_dvout_drop", 32'(gmii_rx_dv_out), 32'(0));
      chk("t5_busy", 32'(busy), 32'(1));
      tick();
    end
    gmii_rx_dv = 1'b0;
    wait_idle("t5_rearm", 1 + GAP);
    chk("t5_drops", 32'(drop_count), 32'(exp_drops));

    // No tlast: drain times out after DRT enabled cycles
    send_frame(10, 1'b1, -1, -1, 1'b0);

    // Async reset mid-frame
    rx_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gmii_rx_dv = 1'b1;
      #1;
      chk("t7_dvout", 32'(gmii_rx_dv_out), 32'(1));
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    chk_reset_values("midreset");
    exp_drops = 0;
    gmii_rx_dv = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t7_release_clken", 32'(rx_clk_enable), 32'(1));
    chk("t7_busy", 32'(busy), 32'(0));

    // Randomized frames at 1000M
    for (int f = 0; f < 30; f++) begin
      int len, flip, tl;
      bit en, tv;
      len  = $urandom_range(1, 40);
      en   = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 39)) : -1;
      tl   = $urandom_range(1, 10);
      tv   = ($urandom_range(0, 3) != 0);
      send_frame(len, en, flip, tl, tv);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_rx_speed_ctrl.md
# eth_rx_speed_ctrl

Receive-side controller that sequences `axis_gmii_rx` for 10/100/1000 Mb/s operation from a fixed 125 MHz clock. It generates the receiver's `clk_enable`/`mii_select` pair and applies speed changes only between frames, never mid-frame. It gates `gmii_rx_dv` so a frame is either passed whole or dropped whole, and it counts dropped frames.

## Interface
- `PRESCALE_100`, 5: clk cycles per enabled cycle at 100 Mb/s.
- `PRESCALE_10`, 50: clk cycles per enabled cycle at 10 Mb/s.
- `GAP_CYCLES`, 4: consecutive quiet enabled cycles required before re-arming.
- `DRAIN_TIMEOUT`, 8: enabled cycles to wait for `m_axis_tlast` after dv falls.

Ports:
- `clk` in 1: single clock, 125 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_speed` in 2: requested speed; 00 = 10M, 01 = 100M, 10 or 11 = 1000M.
- `cfg_speed_valid` in 1: speed request valid.
- `cfg_speed_ready` out 1: request accepted when valid and ready are both high.
- `rx_enable` in 1: 1 = pass frames, 0 = drop frames.
- `gmii_rx_dv` in 1: raw PHY data valid.
- `m_axis_tvalid`, `m_axis_tlast` in 1 each: monitor of the receiver output.
- `gmii_rx_dv_out` out 1: gated dv to the receiver.
- `rx_clk_enable` out 1: receiver `clk_enable`.
- `rx_mii_select` out 1: receiver `mii_select`.
- `speed` out 2: active speed (00, 01 or 10).
- `busy` out 1: high in any state except IDLE.
- `drop_count` out 16: saturating count of dropped frames.

## Operation
- **Enabled cycle (EC):** a clk cycle in which `rx_clk_enable` is 1. FSM decisions on `gmii_rx_dv` occur only on ECs. `m_axis_*` are checked every cycle.
- **Prescaler:** counter runs 0..N-1 with N = PRESCALE_10, PRESCALE_100 or 1. `rx_clk_enable` is registered and goes high the cycle after the count reaches 0. At 1000M it is constantly 1.
- **`rx_mii_select`:** 1 at 10M and 100M, 0 at 1000M. Registered together with `speed`.
- **FSM states:**
  - IDLE: `cfg_speed_ready` = 1.
    - Accepted request → SWITCH. A request has priority over a dv start in the same cycle.
    - Otherwise, EC with dv = 1 → ACTIVE if `rx_enable` = 1, else BLOCK.
  - ACTIVE: `gmii_rx_dv_out` = `gmii_rx_dv`. EC with dv = 0 → DRAIN.
  - DRAIN: on `m_axis_tvalid` & `m_axis_tlast`, or after DRAIN_TIMEOUT ECs → GAP.
  - BLOCK: `gmii_rx_dv_out` = 0. Increment `drop_count` once on entry. EC with dv = 0 → GAP.
  - SWITCH: one clk cycle. Load the latched speed, clear the prescaler → GAP.
  - GAP: count consecutive EC with dv = 0. dv = 1 on an EC clears the count and → BLOCK. Count reaching GAP_CYCLES → IDLE.
- **Gating:** `gmii_rx_dv_out` = `gmii_rx_dv` only in ACTIVE and on the IDLE→ACTIVE transition cycle; 0 everywhere else. `gmii_rx_dv_out` is combinational from `gmii_rx_dv` and state.
- **`rx_enable` changes** take effect only at frame start in IDLE. A frame in progress is never truncated.
- **`drop_count`** saturates at 16'hFFFF.
- **`cfg_speed_ready`** is combinational (state == IDLE). `cfg_speed` is latched on acceptance.

## Timing
- **Reset values:**
  - state IDLE, `speed` = 10, `rx_mii_select` = 0, `rx_clk_enable` = 0.
  - `busy` = 0, `drop_count` = 0, `gmii_rx_dv_out` = 0, `cfg_speed_ready` = 1.
- **First cycle after release:** `rx_clk_enable` = 1.
- **Speed change latency:** acceptance at cycle T gives SWITCH at T+1. `speed`/`rx_mii_select` update at T+2. First new-rate `rx_clk_enable` pulse at T+2.
- **Re-arm latency:** IDLE is reached no earlier than GAP_CYCLES ECs after SWITCH.
- **Reset mid-frame:** outputs return to reset values immediately. The frame is not counted.
- **Simultaneous tlast and timeout in DRAIN:** single transition to GAP.

## Test plan
- **Reset, then 1000M frame of 64 dv-high cycles with `rx_enable` = 1:**
  - `rx_clk_enable` stays 1.
  - `gmii_rx_dv_out` mirrors all 64 cycles.
  - After tlast plus 4 quiet cycles, `busy` = 0 and `drop_count` = 0.
- **Request `cfg_speed` = 01 in IDLE:**
  - Ready handshake completes in one cycle.
  - Two cycles later `speed` = 01 and `rx_mii_select` = 1.
  - `rx_clk_enable` pulses every 5th cycle. Repeat with 00 and check a period of 50.
- **`cfg_speed_valid` asserted during ACTIVE:**
  - `cfg_speed_ready` = 0 until IDLE.
  - `speed` changes only after the frame drains and GAP completes.
- **`rx_enable` = 0 at frame start, then raised mid-frame:**
  - `gmii_rx_dv_out` stays 0 for the whole frame.
  - `drop_count` = 1.
  - The next frame passes.
- **dv re-asserted 2 ECs after the previous frame (inside GAP):** frame dropped, `drop_count` increments.
- **No tlast after dv falls:** DRAIN exits after 8 ECs. Async `rst` pulse mid-ACTIVE returns all outputs to reset values within the same cycle.
